// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES constants and types for the encrypter datapath.
//   AES_BLOCK_WIDTH_IN_BYTES : bytes in one AES block (16)
//   aes_block_t              : one full AES block, byte 0 in the MSBs
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_WIDTH_IN_BYTES = 16;

    typedef logic [AES_BLOCK_WIDTH_IN_BYTES*8-1:0] aes_block_t;

endpackage : aes_pkg

// File: rtl/dvr_if.sv
// ---------------------------------------------------------------------------
// dvr_if
// Data/valid/rdy streaming interface. A beat transfers on a rising clock
// edge when valid && rdy.
//   data  : WIDTH-bit payload, driven by the master
//   valid : payload present, driven by the master
//   rdy   : sink can take a beat, driven by the slave
// ---------------------------------------------------------------------------
interface dvr_if #(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             rdy;

    modport master (output data, output valid, input  rdy);
    modport slave  (input  data, input  valid, output rdy);

endinterface : dvr_if

// File: rtl/dvr_block_packer.sv
// ---------------------------------------------------------------------------
// dvr_block_packer
// Packs RATIO = OUT_WIDTH_IN_BYTES / IN_WIDTH_IN_BYTES narrow beats into one
// full-width output beat (one AES block) for the encrypter.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   msg_in  : dvr_if.slave,  IN_WIDTH_IN_BYTES*8 bits, narrow input stream
//   msg_out : dvr_if.master, OUT_WIDTH_IN_BYTES*8 bits, packed blocks
// Beat k of a block lands at bits [OUT_W-1-k*IN_W -: IN_W] (first beat in
// the MSBs). Output is valid one cycle after the last beat of a block.
// ---------------------------------------------------------------------------
module dvr_block_packer
    import aes_pkg::*;
#(
    parameter int IN_WIDTH_IN_BYTES  = 4,
    parameter int OUT_WIDTH_IN_BYTES = AES_BLOCK_WIDTH_IN_BYTES
) (
    input  logic   clk,
    input  logic   rst,
    dvr_if.slave   msg_in,
    dvr_if.master  msg_out
);

    localparam int IN_W  = IN_WIDTH_IN_BYTES * 8;
    localparam int OUT_W = OUT_WIDTH_IN_BYTES * 8;
    localparam int RATIO = OUT_WIDTH_IN_BYTES / IN_WIDTH_IN_BYTES;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    // Accumulator holds every beat except the last one of a block.
    localparam int ACC_W = (RATIO > 1) ? (RATIO - 1) * IN_W : IN_W;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    if ((OUT_WIDTH_IN_BYTES % IN_WIDTH_IN_BYTES) != 0 || RATIO < 2) begin : g_bad_params
        $error("dvr_block_packer: OUT width must be an integer multiple (>=2) of IN width");
    end

    logic [CW-1:0]    r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [OUT_W-1:0] r_out;
    logic             r_full;

    logic w_in_rdy;
    logic w_in_fire;
    logic w_out_fire;
    logic w_last;

    // Input stalls only while a finished block is waiting on the consumer.
    assign w_in_rdy   = !r_full || msg_out.rdy;
    assign w_in_fire  = msg_in.valid && w_in_rdy;
    assign w_out_fire = r_full && msg_out.rdy;
    assign w_last     = w_in_fire && (r_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_last) begin
                    // Completing beat goes straight into the output register
                    // alongside the accumulated beats, so the output word is
                    // written only once per block and stays stable otherwise.
                    r_out <= {r_acc, msg_in.data};
                    r_cnt <= '0;
                end else begin
                    r_acc[(RATIO - 2 - int'(r_cnt)) * IN_W +: IN_W] <= msg_in.data;
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // A new block completing wins over the drain of the old one; a
            // drain coinciding with a non-final beat leaves the output empty
            // while the next block fills, so no block is presented twice.
            if (w_last) begin
                r_full <= 1'b1;
            end else if (w_out_fire) begin
                r_full <= 1'b0;
            end
        end
    end

    assign msg_in.rdy    = w_in_rdy;
    assign msg_out.valid = r_full;
    assign msg_out.data  = r_out;

endmodule : dvr_block_packer

// File: tb/tb_dvr_block_packer.sv
// ---------------------------------------------------------------------------
// tb_dvr_block_packer
// Directed and scoreboarded checks of dvr_block_packer: a 4->16 byte
// instance (u_dut) and a 8->16 byte instance (u_dut2).
// ---------------------------------------------------------------------------
module tb_dvr_block_packer;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dvr_if #(.WIDTH(32))  a_in  ();
    dvr_if #(.WIDTH(128)) a_out ();
    dvr_if #(.WIDTH(64))  b_in  ();
    dvr_if #(.WIDTH(128)) b_out ();

    dvr_block_packer #(
        .IN_WIDTH_IN_BYTES  (4),
        .OUT_WIDTH_IN_BYTES (16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .msg_in  (a_in),
        .msg_out (a_out)
    );

    dvr_block_packer #(
        .IN_WIDTH_IN_BYTES  (8),
        .OUT_WIDTH_IN_BYTES (16)
    ) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .msg_in  (b_in),
        .msg_out (b_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive_a(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        a_in.valid = v;
        a_in.data  = d;
        a_out.rdy  = r;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [63:0] d, input logic r);
        @(negedge clk);
        b_in.valid = v;
        b_in.data  = d;
        b_out.rdy  = r;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(1'b0, 32'h0, 1'b1);
        drive_b(1'b0, 64'h0, 1'b1);
        n_cmp++;
        if (a_out.valid !== 1'b0 || a_out.data !== 128'h0 || a_in.rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_a: valid=%b data=%h rdy=%b want 0/0/1", a_out.valid, a_out.data, a_in.rdy);
        end
        n_cmp++;
        if (b_out.valid !== 1'b0 || b_out.data !== 128'h0 || b_in.rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_b: valid=%b data=%h rdy=%b want 0/0/1", b_out.valid, b_out.data, b_in.rdy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] beats [4];
        beats[0] = 32'h00010203;
        beats[1] = 32'h04050607;
        beats[2] = 32'h08090A0B;
        beats[3] = 32'h0C0D0E0F;
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, beats[k], 1'b1);
            n_cmp++;
            if (a_in.rdy !== 1'b1 || a_out.valid !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_fill%0d: rdy=%b valid=%b want 1/0", k, a_in.rdy, a_out.valid);
            end
        end
        drive_a(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (a_out.valid !== 1'b1 || a_out.data !== 128'h000102030405060708090A0B0C0D0E0F) begin
            n_bad++;
            $display("FAIL basic_out: valid=%b data=%h want 1/000102030405060708090a0b0c0d0e0f",
                     a_out.valid, a_out.data);
        end
        drive_a(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (a_out.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_one_cycle: valid=%b want 0", a_out.valid);
        end
    endtask

    task automatic test_back_to_back();
        aes_block_t blk1, blk2;
        int nvalid;
        blk1   = {32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
        blk2   = {32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007};
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 32'hA0000000 | 32'(i), 1'b1);
            if (a_out.valid === 1'b1) nvalid++;
            n_cmp++;
            if (a_in.rdy !== 1'b1 || a_out.valid !== (i == 4)) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d: rdy=%b valid=%b want 1/%b", i, a_in.rdy, a_out.valid, (i == 4));
            end
            if (i == 4) begin
                n_cmp++;
                if (a_out.data !== blk1) begin
                    n_bad++;
                    $display("FAIL b2b_blk1: got %h want %h", a_out.data, blk1);
                end
            end
        end
        drive_a(1'b0, 32'h0, 1'b1);
        if (a_out.valid === 1'b1) nvalid++;
        n_cmp++;
        if (a_out.valid !== 1'b1 || a_out.data !== blk2) begin
            n_bad++;
            $display("FAIL b2b_blk2: valid=%b data=%h want 1/%h", a_out.valid, a_out.data, blk2);
        end
        drive_a(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (nvalid != 2 || a_out.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_count: blocks=%0d valid=%b want 2/0", nvalid, a_out.valid);
        end
    endtask

    task automatic test_backpressure();
        aes_block_t blk, nblk;
        blk  = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        nblk = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        drive_a(1'b1, 32'h11111111, 1'b0);
        drive_a(1'b1, 32'h22222222, 1'b0);
        drive_a(1'b1, 32'h33333333, 1'b0);
        drive_a(1'b1, 32'h44444444, 1'b0);
        for (int j = 0; j < 5; j++) begin
            drive_a(1'b1, 32'hDEAD0000 | 32'(j), 1'b0);
            n_cmp++;
            if (a_in.rdy !== 1'b0 || a_out.valid !== 1'b1 || a_out.data !== blk) begin
                n_bad++;
                $display("FAIL bp_hold%0d: rdy=%b valid=%b data=%h want 0/1/%h",
                         j, a_in.rdy, a_out.valid, a_out.data, blk);
            end
        end
        drive_a(1'b1, 32'h55555555, 1'b1);
        n_cmp++;
        if (a_in.rdy !== 1'b1 || a_out.valid !== 1'b1 || a_out.data !== blk) begin
            n_bad++;
            $display("FAIL bp_release: rdy=%b valid=%b data=%h want 1/1/%h", a_in.rdy, a_out.valid, a_out.data, blk);
        end
        drive_a(1'b1, 32'h66666666, 1'b1);
        n_cmp++;
        if (a_out.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drained: valid=%b want 0", a_out.valid);
        end
        drive_a(1'b1, 32'h77777777, 1'b1);
        drive_a(1'b1, 32'h88888888, 1'b1);
        drive_a(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (a_out.valid !== 1'b1 || a_out.data !== nblk) begin
            n_bad++;
            $display("FAIL bp_next_blk: valid=%b data=%h want 1/%h", a_out.valid, a_out.data, nblk);
        end
        drive_a(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_mid_reset();
        aes_block_t fresh;
        fresh = {32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
        drive_a(1'b1, 32'hBADBAD00, 1'b1);
        drive_a(1'b1, 32'hBADBAD01, 1'b1);
        @(negedge clk);
        a_in.valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_out.valid !== 1'b0 || a_in.rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_partial: valid=%b rdy=%b want 0/1", a_out.valid, a_in.rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_a(1'b1, 32'hC0C0C0C0, 1'b1);
        drive_a(1'b1, 32'hC1C1C1C1, 1'b1);
        drive_a(1'b1, 32'hC2C2C2C2, 1'b1);
        drive_a(1'b1, 32'hC3C3C3C3, 1'b1);
        drive_a(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (a_out.valid !== 1'b1 || a_out.data !== fresh) begin
            n_bad++;
            $display("FAIL rst_fresh_blk: valid=%b data=%h want 1/%h", a_out.valid, a_out.data, fresh);
        end
        // Park a full block, then reset between clock edges.
        drive_a(1'b1, 32'hE0E0E0E0, 1'b0);
        drive_a(1'b1, 32'hE1E1E1E1, 1'b0);
        drive_a(1'b1, 32'hE2E2E2E2, 1'b0);
        drive_a(1'b1, 32'hE3E3E3E3, 1'b0);
        drive_a(1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (a_out.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pending_pre: valid=%b want 1", a_out.valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_out.valid !== 1'b0 || a_out.data !== 128'h0) begin
            n_bad++;
            $display("FAIL rst_pending_async: valid=%b data=%h want 0/0", a_out.valid, a_out.data);
        end
        @(negedge clk);
        rst = 1'b0;
        a_out.rdy = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] acc_q [$];
        aes_block_t  exp_q [$];
        aes_block_t  exp_blk;
        logic        v, r, exp_rdy;
        logic [31:0] d;
        int          fed, got, cyc;
        fed = 0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
            v = (fed < 4000) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            d = $urandom;
            drive_a(v, d, r);
            exp_rdy = !a_out.valid || r;
            n_cmp++;
            if (a_in.rdy !== exp_rdy) begin
                n_bad++;
                $display("FAIL rand_rdy cyc%0d: got %b want %b", cyc, a_in.rdy, exp_rdy);
            end
            if (a_out.valid === 1'b1 && r) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra cyc%0d: got %h want no block", cyc, a_out.data);
                end else begin
                    exp_blk = exp_q.pop_front();
                    if (a_out.data !== exp_blk) begin
                        n_bad++;
                        $display("FAIL rand_data blk%0d: got %h want %h", got, a_out.data, exp_blk);
                    end
                end
                got++;
            end
            if (v && exp_rdy) begin
                acc_q.push_back(d);
                fed++;
                if (acc_q.size() == 4) begin
                    exp_q.push_back({acc_q[0], acc_q[1], acc_q[2], acc_q[3]});
                    acc_q.delete();
                end
            end
            cyc++;
        end
        n_cmp++;
        if (got != 1000 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_count: blocks=%0d pending=%0d want 1000/0", got, exp_q.size());
        end
        drive_a(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_ratio2();
        drive_b(1'b1, 64'h0011223344556677, 1'b1);
        n_cmp++;
        if (b_in.rdy !== 1'b1 || b_out.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL r2_fill: rdy=%b valid=%b want 1/0", b_in.rdy, b_out.valid);
        end
        drive_b(1'b1, 64'h8899AABBCCDDEEFF, 1'b1);
        drive_b(1'b0, 64'h0, 1'b1);
        n_cmp++;
        if (b_out.valid !== 1'b1 || b_out.data !== 128'h00112233445566778899AABBCCDDEEFF) begin
            n_bad++;
            $display("FAIL r2_out: valid=%b data=%h want 1/00112233445566778899aabbccddeeff",
                     b_out.valid, b_out.data);
        end
        n_cmp++;
        if (b_out.data[127:64] !== 64'h0011223344556677) begin
            n_bad++;
            $display("FAIL r2_msb: got %h want 0011223344556677", b_out.data[127:64]);
        end
        drive_b(1'b0, 64'h0, 1'b1);
        n_cmp++;
        if (b_out.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL r2_one_cycle: valid=%b want 0", b_out.valid);
        end
    endtask

    initial begin
        rst        = 1'b1;
        a_in.valid = 1'b0;
        a_in.data  = '0;
        a_out.rdy  = 1'b1;
        b_in.valid = 1'b0;
        b_in.data  = '0;
        b_out.rdy  = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_ratio2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dvr_block_packer
